// File: rtl/sram_port_arbiter.sv
// Three-way arbiter in front of a single-port, 1-cycle-read block SRAM.
// Masters: video scan-out reads, game-logic read/write, and a built-in
// clear engine that fills the whole array with one value. The grant is
// combinational, and the SRAM strobes follow the winner in the same cycle.
// Read data is returned one cycle later to the master that issued the read.
module sram_port_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int RAM_SIZE   = 65536,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  vid_req,
    input  logic [ADDR_WIDTH-1:0] vid_addr,
    output logic                  vid_ready,
    output logic                  vid_rvalid,
    output logic [DATA_WIDTH-1:0] vid_rdata,
    input  logic                  usr_valid,
    input  logic                  usr_we,
    input  logic [ADDR_WIDTH-1:0] usr_addr,
    input  logic [DATA_WIDTH-1:0] usr_wdata,
    output logic                  usr_ready,
    output logic                  usr_rvalid,
    output logic [DATA_WIDTH-1:0] usr_rdata,
    input  logic                  clr_start,
    input  logic [DATA_WIDTH-1:0] clr_value,
    output logic                  clr_busy,
    output logic                  clr_done,
    output logic                  sram_en,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    input  logic [DATA_WIDTH-1:0] sram_rdata
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam int CLR_W  = ADDR_WIDTH + 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
    // The clear counter is one bit wider than the address so it never wraps.
    localparam logic [CLR_W-1:0]  CLR_LAST = CLR_W'(RAM_SIZE - 1);

    typedef enum logic [1:0] {ARB, CLEAR, DONE} state_e;

    state_e                state_q, state_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic [CLR_W-1:0]      clr_addr_q, clr_addr_d;
    logic [DATA_WIDTH-1:0] clr_val_q, clr_val_d;
    logic                  rd_pend_q, rd_pend_d;
    logic                  rd_usr_q, rd_usr_d;
    logic                  grant_vid, grant_usr, grant_clr;

    // Pick the winner, drive the SRAM for it, and compute the next state.
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        clr_addr_d = clr_addr_q;
        clr_val_d  = clr_val_q;
        grant_vid  = 1'b0;
        grant_usr  = 1'b0;
        grant_clr  = 1'b0;
        sram_en    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;

        // While reset is held nothing is granted, even if masters are requesting.
        if (reset_n) begin
            if (state_q == CLEAR) begin
                if (vid_req) grant_vid = 1'b1;
                else         grant_clr = 1'b1;
            end else begin
                if (usr_valid && wait_q == WAIT_MAX) grant_usr = 1'b1;
                else if (vid_req)                    grant_vid = 1'b1;
                else if (usr_valid)                  grant_usr = 1'b1;
            end
        end

        if (grant_vid) begin
            sram_en   = 1'b1;
            sram_addr = vid_addr;
        end else if (grant_usr) begin
            sram_en    = 1'b1;
            sram_we    = usr_we;
            sram_addr  = usr_addr;
            sram_wdata = usr_we ? usr_wdata : '0;
        end else if (grant_clr) begin
            sram_en    = 1'b1;
            sram_we    = 1'b1;
            sram_addr  = clr_addr_q[ADDR_WIDTH-1:0];
            sram_wdata = clr_val_q;
        end

        // Tag for routing next cycle's read data; writes return nothing.
        rd_pend_d = grant_vid | (grant_usr & ~usr_we);
        rd_usr_d  = grant_usr;

        // Starvation counter: counts cycles usr is left waiting behind vid.
        if (state_q == CLEAR || !usr_valid || grant_usr) wait_d = '0;
        else if (wait_q != WAIT_MAX)                     wait_d = wait_q + WAIT_W'(1);

        case (state_q)
            ARB: begin
                if (clr_start) begin
                    state_d    = CLEAR;
                    clr_val_d  = clr_value;
                    clr_addr_d = '0;
                end
            end
            CLEAR: begin
                if (grant_clr) begin
                    clr_addr_d = clr_addr_q + CLR_W'(1);
                    if (clr_addr_q == CLR_LAST) state_d = DONE;
                end
            end
            default: state_d = ARB;
        endcase
    end

    // State and return-tag registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ARB;
            wait_q     <= '0;
            clr_addr_q <= '0;
            clr_val_q  <= '0;
            rd_pend_q  <= 1'b0;
            rd_usr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            clr_addr_q <= clr_addr_d;
            clr_val_q  <= clr_val_d;
            rd_pend_q  <= rd_pend_d;
            rd_usr_q   <= rd_usr_d;
        end
    end

    assign vid_ready  = grant_vid;
    assign usr_ready  = grant_usr;
    assign vid_rvalid = rd_pend_q & ~rd_usr_q;
    assign usr_rvalid = rd_pend_q &  rd_usr_q;
    assign vid_rdata  = vid_rvalid ? sram_rdata : '0;
    assign usr_rdata  = usr_rvalid ? sram_rdata : '0;
    assign clr_busy   = (state_q == CLEAR);
    assign clr_done   = (state_q == DONE);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: a behavioural SRAM, a transaction-level
// reference model, directed scenarios and a randomized traffic phase.
module tb_sram_port_arbiter;

    localparam int DW = 8;
    localparam int AW = 16;
    localparam int RS = 16;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          vid_req, vid_ready, vid_rvalid;
    logic [AW-1:0] vid_addr;
    logic [DW-1:0] vid_rdata;
    logic          usr_valid, usr_we, usr_ready, usr_rvalid;
    logic [AW-1:0] usr_addr;
    logic [DW-1:0] usr_wdata, usr_rdata;
    logic          clr_start, clr_busy, clr_done;
    logic [DW-1:0] clr_value;
    logic          sram_en, sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata = '0;

    always #5 clk = ~clk;

    sram_port_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_SIZE(RS), .MAX_WAIT(MW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ready(vid_ready),
        .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
        .usr_valid(usr_valid), .usr_we(usr_we), .usr_addr(usr_addr),
        .usr_wdata(usr_wdata), .usr_ready(usr_ready), .usr_rvalid(usr_rvalid),
        .usr_rdata(usr_rdata),
        .clr_start(clr_start), .clr_value(clr_value), .clr_busy(clr_busy),
        .clr_done(clr_done),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    // Power-up contents are a fixed function of the address.
    function automatic logic [DW-1:0] init_val(input int a);
        logic [15:0] av;
        av = 16'(a);
        return av[7:0] ^ av[15:8] ^ 8'h5A;
    endfunction

    // Behavioural SRAM: registered read, write-through on write.
    logic [DW-1:0] mem [0:65535];
    bit            written [0:65535];
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we) begin
                mem[sram_addr]     <= sram_wdata;
                written[sram_addr] <= 1'b1;
                sram_rdata         <= sram_wdata;
            end else begin
                sram_rdata <= written[sram_addr] ? mem[sram_addr] : init_val(int'(sram_addr));
            end
        end
    end

    // Reference model state: mode 0 = arbitrating, 1 = clearing, 2 = clear just finished.
    logic [DW-1:0] ref_mem [0:65535];
    int            m_mode, m_wait, m_ptr;
    logic [DW-1:0] m_val, m_pd;
    bit            m_pv, m_pu;

    int errors = 0;
    int checks = 0;

    // Observed values of the most recent cycle, for directed checks.
    bit            o_vr, o_ur, o_busy, o_done, o_urv;
    logic [DW-1:0] o_urd;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_wait = 0; m_ptr = 0; m_val = '0;
        m_pv = 0; m_pu = 0; m_pd = '0;
    endtask

    task automatic idle();
        vid_req = 0; vid_addr = '0; usr_valid = 0; usr_we = 0;
        usr_addr = '0; usr_wdata = '0; clr_start = 0; clr_value = '0;
    endtask

    // One clock: check the DUT against the model mid-cycle, then advance the model.
    task automatic tick();
        bit            ev, eu, ec, een, ewe;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        bit            c_vr, c_uv, c_we, c_cs;
        logic [AW-1:0] c_va, c_ua;
        logic [DW-1:0] c_wd, c_cv;
        @(negedge clk);
        c_vr = vid_req; c_va = vid_addr; c_uv = usr_valid; c_we = usr_we;
        c_ua = usr_addr; c_wd = usr_wdata; c_cs = clr_start; c_cv = clr_value;
        ev = 0; eu = 0; ec = 0;
        if (m_mode == 1) begin
            if (c_vr) ev = 1; else ec = 1;
        end else if (c_uv && m_wait == MW) eu = 1;
        else if (c_vr) ev = 1;
        else if (c_uv) eu = 1;
        een = ev | eu | ec;
        ewe = ec | (eu & c_we);
        ea  = ev ? c_va : eu ? c_ua : ec ? AW'(m_ptr) : '0;
        ed  = ec ? m_val : (eu && c_we) ? c_wd : '0;
        chk("ctrl", 64'({vid_ready, usr_ready, clr_busy, clr_done}),
                    64'({ev, eu, (m_mode == 1), (m_mode == 2)}));
        chk("sram", 64'({sram_en, sram_we, sram_addr, sram_wdata}), 64'({een, ewe, ea, ed}));
        chk("vid_ret", 64'({vid_rvalid, vid_rdata}), 64'({m_pv, (m_pv ? m_pd : 8'h00)}));
        chk("usr_ret", 64'({usr_rvalid, usr_rdata}), 64'({m_pu, (m_pu ? m_pd : 8'h00)}));
        o_vr = vid_ready; o_ur = usr_ready; o_busy = clr_busy; o_done = clr_done;
        o_urv = usr_rvalid; o_urd = usr_rdata;
        @(posedge clk);
        m_pd = ev ? ref_mem[c_va] : (eu && !c_we) ? ref_mem[c_ua] : '0;
        m_pv = ev;
        m_pu = eu && !c_we;
        if (eu && c_we) ref_mem[c_ua] = c_wd;
        if (ec) ref_mem[m_ptr] = m_val;
        if (m_mode == 1 || !c_uv || eu) m_wait = 0;
        else if (m_wait < MW) m_wait++;
        case (m_mode)
            0: if (c_cs) begin m_mode = 1; m_ptr = 0; m_val = c_cv; end
            1: if (ec) begin
                   if (m_ptr == RS - 1) m_mode = 2;
                   m_ptr++;
               end
            default: m_mode = 0;
        endcase
        #1;
    endtask

    initial begin
        int first_ur, vid_low, busy_n, usr_in_clear;
        bit seen_done, ok, got6, done_grant;
        logic [DW-1:0] d6;

        for (int a = 0; a < 65536; a++) ref_mem[a] = init_val(a);
        model_reset();
        idle();

        // Reset state: requests present, but every output must stay low.
        reset_n = 0;
        vid_req = 1; usr_valid = 1; clr_start = 1;
        #2;
        chk("reset_outputs", 64'({vid_ready, vid_rvalid, vid_rdata, usr_ready, usr_rvalid, usr_rdata,
                                  clr_busy, clr_done, sram_en, sram_we, sram_addr, sram_wdata}), 64'd0);
        idle();
        @(posedge clk); #1;
        reset_n = 1;
        tick();

        // Starvation limit: usr waits MW cycles behind vid, then is forced through once.
        vid_req = 1; vid_addr = 16'h0020;
        usr_valid = 1; usr_we = 0; usr_addr = 16'h0010;
        first_ur = 0; vid_low = 0; got6 = 0; d6 = '0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (o_ur && first_ur == 0) first_ur = i;
            if (!o_vr) vid_low++;
            if (i == 6) begin got6 = o_urv; d6 = o_urd; end
        end
        chk("starve_grant_cycle", 64'(first_ur), 64'd5);
        chk("starve_vid_low_cycles", 64'(vid_low), 64'd1);
        chk("starve_rdata", 64'({got6, d6}), 64'({1'b1, init_val(16'h0010)}));
        idle();
        tick();

        // Write then read back the same word; the write returns nothing.
        usr_valid = 1; usr_we = 1; usr_addr = 16'h1234; usr_wdata = 8'hA5;
        tick();
        usr_we = 0; usr_wdata = '0;
        tick();
        chk("write_no_rvalid", 64'(o_urv), 64'd0);
        idle();
        tick();
        chk("readback", 64'({o_urv, o_urd}), 64'({1'b1, 8'hA5}));

        // Full clear with no video traffic.
        clr_start = 1; clr_value = 8'h3C;
        tick();
        idle();
        busy_n = 0; seen_done = 0;
        for (int i = 0; i < 40 && !seen_done; i++) begin
            tick();
            if (o_busy) busy_n++;
            if (o_done) seen_done = 1;
        end
        chk("clear_done_seen", 64'(seen_done), 64'd1);
        chk("clear_busy_cycles", 64'(busy_n), 64'(RS));
        ok = 1;
        for (int a = 0; a < RS; a++) if (mem[a] !== 8'h3C) ok = 0;
        chk("clear_contents", 64'(ok), 64'd1);
        tick();

        // Clear interleaved with video reads on alternate cycles.
        clr_start = 1; clr_value = 8'hC3;
        tick();
        idle();
        busy_n = 0; seen_done = 0;
        for (int k = 0; k < 80 && !seen_done; k++) begin
            vid_req  = (k % 2 == 0);
            vid_addr = AW'($urandom_range(0, 31));
            tick();
            if (o_busy) busy_n++;
            if (o_done) seen_done = 1;
        end
        idle();
        chk("clear_vid_done_seen", 64'(seen_done), 64'd1);
        chk("clear_vid_busy_cycles", 64'(busy_n), 64'(2 * RS));
        tick();

        // usr access in the start cycle is served; afterwards usr is held off until DONE.
        clr_start = 1; clr_value = 8'h77;
        usr_valid = 1; usr_we = 0; usr_addr = 16'h0003;
        tick();
        chk("clr_start_usr_served", 64'(o_ur), 64'd1);
        clr_start = 0;
        usr_in_clear = 0; done_grant = 0; seen_done = 0;
        for (int i = 0; i < 40 && !seen_done; i++) begin
            tick();
            if (o_busy && o_ur) usr_in_clear++;
            if (o_done) begin seen_done = 1; done_grant = o_ur; end
        end
        idle();
        chk("usr_blocked_in_clear", 64'(usr_in_clear), 64'd0);
        chk("usr_granted_on_done", 64'({seen_done, done_grant}), 64'b11);
        tick();

        // Reset in the middle of a clear, after seven words have been written.
        clr_start = 1; clr_value = 8'hE1;
        tick();
        idle();
        for (int i = 0; i < 7; i++) tick();
        vid_req = 1; usr_valid = 1; usr_addr = 16'h0005;
        reset_n = 0;
        #1;
        chk("midclear_reset_outputs", 64'({vid_ready, vid_rvalid, vid_rdata, usr_ready, usr_rvalid, usr_rdata,
                                           clr_busy, clr_done, sram_en, sram_we, sram_addr, sram_wdata}), 64'd0);
        @(posedge clk); #1;
        idle();
        reset_n = 1;
        model_reset();
        tick();
        chk("after_reset_not_busy", 64'(o_busy), 64'd0);
        tick();
        chk("clear_not_resumed", 64'(o_busy), 64'd0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            vid_req   = ($urandom_range(0, 2) == 0);
            vid_addr  = AW'($urandom_range(0, 31));
            usr_valid = ($urandom_range(0, 1) == 1);
            usr_we    = ($urandom_range(0, 2) == 0);
            usr_addr  = AW'($urandom_range(0, 31));
            usr_wdata = DW'($urandom);
            clr_start = ($urandom_range(0, 39) == 0);
            clr_value = DW'($urandom);
            tick();
        end
        idle();
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
